dram_rst_seq: RTL and testbench

- Reset/power-on sequencer in the DRAM sys_clk domain, directly upstream of the DRAM controller wrapper's sys_rst input.
- Synchronises reset deassertion, then holds the controller in reset for a fixed interval.
- Releases reset and supervises init_calib_complete with a timeout.
- On timeout or calibration loss, re-sequences up to a retry limit; otherwise parks in a sticky FAIL.

---
 rtl/dram_rst_seq_if.sv | 42 ++++
 rtl/dram_rst_seq.sv | 165 ++++++++++++++++
 tb/tb_dram_rst_seq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_rst_seq_if.sv
// Sequencer-to-DRAM-controller reset and calibration signals.
// i_sw_rst is present only when DRAM_RST_SEQ_SWRST_EN is defined.
interface dram_rst_seq_if #(
  parameter int unsigned MAX_RETRIES = 3
);
  localparam int unsigned RETRY_WIDTH = $clog2(MAX_RETRIES + 1);

  logic                   i_init_calib_complete;
`ifdef DRAM_RST_SEQ_SWRST_EN
  logic                   i_sw_rst;
`endif
  logic                   o_sys_rst;
  logic                   o_ready;
  logic                   o_fail;
  logic [RETRY_WIDTH-1:0] o_retry_cnt;
  logic [2:0]             o_state;

  // master: the sequencer; slave: whoever consumes the reset and status.
  modport master (
    input  i_init_calib_complete,
`ifdef DRAM_RST_SEQ_SWRST_EN
    input  i_sw_rst,
`endif
    output o_sys_rst,
    output o_ready,
    output o_fail,
    output o_retry_cnt,
    output o_state
  );

  modport slave (
    output i_init_calib_complete,
`ifdef DRAM_RST_SEQ_SWRST_EN
    output i_sw_rst,
`endif
    input  o_sys_rst,
    input  o_ready,
    input  o_fail,
    input  o_retry_cnt,
    input  o_state
  );
endinterface

// File: rtl/dram_rst_seq.sv
// DRAM controller reset/power-on sequencer: hold, calibrate with timeout, retry, sticky fail.
// Defining DRAM_RST_SEQ_SWRST_EN adds the i_sw_rst software re-sequence input.
module dram_rst_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter int unsigned CALIB_TIMEOUT = 16777216,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_WIDTH     = 25
) (
  input logic            clk_166_67_mhz,
  input logic            dram_rstx_async,
  dram_rst_seq_if.master bus
);
  localparam int unsigned RETRY_WIDTH = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_WIDTH-1:0]   HoldLast  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CalibLast = CNT_WIDTH'(CALIB_TIMEOUT - 1);
  localparam logic [RETRY_WIDTH-1:0] RetryMax  = RETRY_WIDTH'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StReset = 3'd0,
    StHold  = 3'd1,
    StCalib = 3'd2,
    StReady = 3'd3,
    StFail  = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [SYNC_STAGES-1:0] r_calib_sync;
  state_e                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [RETRY_WIDTH-1:0] r_retry_cnt;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   r_fail;
  logic                   r_seen_low;

  logic w_rst_rel;
  logic w_calib_s;
  logic w_can_retry;
  logic w_sw_rst;

`ifdef DRAM_RST_SEQ_SWRST_EN
  assign w_sw_rst = bus.i_sw_rst;
`else
  assign w_sw_rst = 1'b0;
`endif

  // Reset release and calib flag both cross into this domain through SYNC_STAGES flops.
  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      r_rst_sync   <= '0;
      r_calib_sync <= '0;
    end else begin
      r_rst_sync   <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
      r_calib_sync <= {r_calib_sync[SYNC_STAGES-2:0], bus.i_init_calib_complete};
    end
  end

  assign w_rst_rel   = r_rst_sync[SYNC_STAGES-1];
  assign w_calib_s   = r_calib_sync[SYNC_STAGES-1];
  assign w_can_retry = (r_retry_cnt < RetryMax);

  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      r_state     <= StReset;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_seen_low  <= 1'b0;
    end else if (!w_rst_rel) begin
      r_state     <= StReset;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_seen_low  <= 1'b0;
    end else if (w_sw_rst && (r_state != StReset)) begin
      r_state     <= StHold;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_seen_low  <= 1'b0;
    end else begin
      // A low calib must be seen in this attempt before a high one counts as success.
      if (((r_state == StHold) || (r_state == StCalib)) && !w_calib_s) begin
        r_seen_low <= 1'b1;
      end
      unique case (r_state)
        StReset: begin
          r_state    <= StHold;
          r_cnt      <= '0;
          r_sys_rst  <= 1'b1;
          r_seen_low <= 1'b0;
        end
        StHold: begin
          if (r_cnt == HoldLast) begin
            r_state   <= StCalib;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StCalib: begin
          if (r_seen_low && w_calib_s) begin
            r_state <= StReady;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == CalibLast) begin
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            if (w_can_retry) begin
              r_state     <= StHold;
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_seen_low  <= 1'b0;
            end else begin
              r_state <= StFail;
              r_fail  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StReady: begin
          if (!w_calib_s) begin
            r_ready   <= 1'b0;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            if (w_can_retry) begin
              r_state     <= StHold;
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_seen_low  <= 1'b0;
            end else begin
              r_state <= StFail;
              r_fail  <= 1'b1;
            end
          end
        end
        StFail: begin
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
          r_fail    <= 1'b1;
        end
        default: begin
          r_state   <= StReset;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sys_rst   = r_sys_rst;
  assign bus.o_ready     = r_ready;
  assign bus.o_fail      = r_fail;
  assign bus.o_retry_cnt = r_retry_cnt;
  assign bus.o_state     = r_state;

endmodule

// File: tb/tb_dram_rst_seq.sv
// Bench for dram_rst_seq: directed scenarios plus random calib/reset activity,
// checked every cycle against a phase/elapsed-time model of the sequencer.
module tb_dram_rst_seq;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 16;
  localparam int unsigned TMO  = 100;
  localparam int unsigned MAXR = 2;
  localparam int unsigned CW   = 8;

  localparam int PH_RESET = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_CALIB = 2;
  localparam int PH_READY = 3;
  localparam int PH_FAIL  = 4;

  logic clk   = 1'b0;
  logic rstx  = 1'b0;
  logic calib = 1'b0;
  logic sw    = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #3 clk = ~clk;

  dram_rst_seq_if #(.MAX_RETRIES(MAXR)) u_if ();

  assign u_if.i_init_calib_complete = calib;
`ifdef DRAM_RST_SEQ_SWRST_EN
  assign u_if.i_sw_rst = sw;
`endif

  dram_rst_seq #(
    .SYNC_STAGES  (SYNC),
    .HOLD_CYCLES  (HOLD),
    .CALIB_TIMEOUT(TMO),
    .MAX_RETRIES  (MAXR),
    .CNT_WIDTH    (CW)
  ) u_dut (
    .clk_166_67_mhz (clk),
    .dram_rstx_async(rstx),
    .bus            (u_if)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase, time spent in phase, retries used, and a FIFO delaying calib by SYNC edges.
  int m_phase;
  int m_elapsed;
  int m_attempts;
  int m_rel;
  bit m_low;
  bit m_q[$];

  task automatic m_reset();
    m_phase    = PH_RESET;
    m_elapsed  = 0;
    m_attempts = 0;
    m_rel      = 0;
    m_low      = 1'b0;
    m_q        = {};
    repeat (SYNC) m_q.push_back(1'b0);
  endtask

  task automatic m_retry_or_fail();
    if (m_attempts < int'(MAXR)) begin
      m_attempts++;
      m_phase   = PH_HOLD;
      m_elapsed = 0;
      m_low     = 1'b0;
    end else begin
      m_phase = PH_FAIL;
    end
  endtask

  task automatic m_step(input bit cs, input bit swr);
`ifdef DRAM_RST_SEQ_SWRST_EN
    if (swr && m_phase != PH_RESET) begin
      m_phase    = PH_HOLD;
      m_elapsed  = 0;
      m_attempts = 0;
      m_low      = 1'b0;
      return;
    end
`else
    if (swr) begin
      m_low = m_low;
    end
`endif
    case (m_phase)
      PH_RESET: begin
        m_phase   = PH_HOLD;
        m_elapsed = 0;
        m_low     = 1'b0;
      end
      PH_HOLD: begin
        if (!cs) m_low = 1'b1;
        m_elapsed++;
        if (m_elapsed == int'(HOLD)) begin
          m_phase   = PH_CALIB;
          m_elapsed = 0;
        end
      end
      PH_CALIB: begin
        if (m_low && cs) begin
          m_phase = PH_READY;
        end else begin
          if (!cs) m_low = 1'b1;
          m_elapsed++;
          if (m_elapsed == int'(TMO)) m_retry_or_fail();
        end
      end
      PH_READY: if (!cs) m_retry_or_fail();
      default: ;
    endcase
  endtask

  initial begin
    bit cs;
    m_reset();
    forever begin
      @(posedge clk or negedge rstx);
      if (!rstx) begin
        m_reset();
      end else begin
        cs = m_q.pop_front();
        m_q.push_back(calib);
        if (m_rel < int'(SYNC)) m_rel++;
        else m_step(cs, sw);
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  initial begin
    logic [7:0] exp_v;
    logic [7:0] got_v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_v = {(m_phase != PH_CALIB) && (m_phase != PH_READY), m_phase == PH_READY,
                 m_phase == PH_FAIL, 2'(m_attempts), 3'(m_phase)};
        got_v = {u_if.o_sys_rst, u_if.o_ready, u_if.o_fail, u_if.o_retry_cnt, u_if.o_state};
        check("cycle", {24'd0, got_v}, {24'd0, exp_v});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (u_if.o_state !== 3'(st) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'd0, u_if.o_state}, st);
  endtask

  task automatic measure_hold(input string name);
    int n = 0;
    while (u_if.o_state === 3'(PH_HOLD) && u_if.o_sys_rst === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, n, HOLD);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_sys_rst"}, {31'd0, u_if.o_sys_rst}, 1);
    check({pfx, "_ready"}, {31'd0, u_if.o_ready}, 0);
    check({pfx, "_fail"}, {31'd0, u_if.o_fail}, 0);
    check({pfx, "_retry"}, {30'd0, u_if.o_retry_cnt}, 0);
    check({pfx, "_state"}, {29'd0, u_if.o_state}, PH_RESET);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit saw;
    // Power-on: reset values, one 16-cycle HOLD, READY two edges after calib sampled.
    cyc(3);
    chk_en = 1'b1;
    check_reset_vals("por");
    rstx = 1'b1;
    wait_state(PH_HOLD, 10, "por_to_hold");
    measure_hold("por_hold_len");
    check("por_in_calib", {29'd0, u_if.o_state}, PH_CALIB);
    cyc(30);
    calib = 1'b1;
    cyc(1);
    check("lat_edge0", {31'd0, u_if.o_ready}, 0);
    cyc(1);
    check("lat_edge1", {31'd0, u_if.o_ready}, 0);
    cyc(1);
    check("lat_edge2", {31'd0, u_if.o_ready}, 1);
    check("por_retry", {30'd0, u_if.o_retry_cnt}, 0);

    // Calibration loss: 1-cycle drop in READY.
    calib = 1'b0;
    n = 0;
    while (n < 3 && u_if.o_ready !== 1'b0) begin
      @(negedge clk);
      n++;
      calib = 1'b1;
    end
    check("loss_ready_low", {31'd0, u_if.o_ready}, 0);
    check("loss_state", {29'd0, u_if.o_state}, PH_HOLD);
    check("loss_retry", {30'd0, u_if.o_retry_cnt}, 1);

    // Async reset mid-CALIB with counter at 50 and one retry used.
    calib = 1'b0;
    wait_state(PH_CALIB, 40, "mid_to_calib");
    cyc(50);
    check("mid_retry_before", {30'd0, u_if.o_retry_cnt}, 1);
    #1 rstx = 1'b0;
    #1 check_reset_vals("mid_rst");
    cyc(2);
    rstx = 1'b1;
    wait_state(PH_HOLD, 10, "mid_to_hold");
    measure_hold("mid_hold_len");

    // Timeout retry: calib low through first window, rises 10 cycles into the second.
    wait_state(PH_HOLD, 150, "tmo_to_hold");
    check("tmo_retry", {30'd0, u_if.o_retry_cnt}, 1);
    measure_hold("tmo_hold_len");
    cyc(10);
    calib = 1'b1;
    wait_state(PH_READY, 10, "tmo_to_ready");
    check("tmo_ready", {31'd0, u_if.o_ready}, 1);
    check("tmo_retry_after", {30'd0, u_if.o_retry_cnt}, 1);

    // Stale calib: held high throughout, never READY, ends in FAIL.
    #1 rstx = 1'b0;
    calib = 1'b1;
    cyc(3);
    rstx = 1'b1;
    n = 0;
    saw = 1'b0;
    while (u_if.o_state !== 3'(PH_FAIL) && n < 600) begin
      @(negedge clk);
      n++;
      if (u_if.o_ready === 1'b1) saw = 1'b1;
    end
    check("stale_never_ready", {31'd0, saw}, 0);
    check("stale_state", {29'd0, u_if.o_state}, PH_FAIL);
    check("stale_retry", {30'd0, u_if.o_retry_cnt}, 2);
    check("stale_fail", {31'd0, u_if.o_fail}, 1);
    check("stale_sys_rst", {31'd0, u_if.o_sys_rst}, 1);
    cyc(20);
    check("stale_sticky", {31'd0, u_if.o_fail}, 1);

`ifdef DRAM_RST_SEQ_SWRST_EN
    // Software reset out of FAIL.
    sw = 1'b1;
    cyc(1);
    sw = 1'b0;
    check("sw_fail", {31'd0, u_if.o_fail}, 0);
    check("sw_retry", {30'd0, u_if.o_retry_cnt}, 0);
    check("sw_state", {29'd0, u_if.o_state}, PH_HOLD);
    calib = 1'b0;
    wait_state(PH_CALIB, 40, "sw_to_calib");
    cyc(5);
    calib = 1'b1;
    wait_state(PH_READY, 10, "sw_to_ready");
`endif

    // Random calib activity with occasional resets.
    #1 rstx = 1'b0;
    cyc(2);
    rstx = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 11);
      if (act == 0) begin
        #1 rstx = 1'b0;
        cyc($urandom_range(1, 4));
        rstx = 1'b1;
      end else if (act == 1) begin
        sw = 1'b1;
        cyc(1);
        sw = 1'b0;
      end else begin
        calib = ($urandom_range(0, 2) != 0);
        cyc($urandom_range(1, 70));
      end
    end
    cyc(5);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
